// File: rtl/inv_ctrl.sv
// Inventory/access controller: turns decoded reader commands into generator update pulses,
// tracks tag inventory state and requests backscatter replies through a req/ack handshake.
module inv_ctrl (
   input  logic        DOUB_BLF,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd_type,
   input  logic [3:0]  cmd_q,
   input  logic [2:0]  cmd_updn,
   input  logic        cmd_sess_ok,
   input  logic [15:0] cmd_rn,
   input  logic        slot_valid,
   input  logic [15:0] rn16,
   input  logic [15:0] handle,
   input  logic        reply_ack,
   output logic [3:0]  Q,
   output logic        Q_update,
   output logic        slot_update,
   output logic        rn16_update,
   output logic        handle_update,
   output logic [2:0]  tag_state,
   output logic        reply_req,
   output logic [1:0]  reply_type
);

   typedef enum logic [2:0] {
      StReady = 3'd0,
      StArb   = 3'd1,
      StReply = 3'd2,
      StAcked = 3'd3,
      StOpen  = 3'd4
   } tag_state_e;

   localparam logic [2:0] CmdQuery    = 3'd0;
   localparam logic [2:0] CmdQueryAdj = 3'd1;
   localparam logic [2:0] CmdQueryRep = 3'd2;
   localparam logic [2:0] CmdAck      = 3'd3;
   localparam logic [2:0] CmdReqRn    = 3'd4;
   localparam logic [2:0] CmdNak      = 3'd5;

   localparam logic [1:0] RepRn16   = 2'd0;
   localparam logic [1:0] RepEpc    = 2'd1;
   localparam logic [1:0] RepHandle = 2'd2;

   tag_state_e  state_q, state_d;
   logic [3:0]  q_q, q_d, q_adj;
   logic [1:0]  ev_q, ev_d;
   logic        qupd_q, qupd_d, supd_q, supd_d, rupd_q, rupd_d, hupd_q, hupd_d;
   logic        req_q, req_d, pend_q, pend_d;
   logic [1:0]  rtype_q, rtype_d, pend_type_q, pend_type_d;
   logic        epc_set, pend_set;
   logic [1:0]  pend_set_type;
   logic        cmd_acc, rn_match, hd_match, in_round, secured;

   // ev_q counts evaluation cycles 1..3; commands arriving while it is non-zero are dropped
   assign cmd_acc  = cmd_valid && (ev_q == 2'd0) && (cmd_type < 3'd6);
   assign rn_match = (cmd_rn == rn16);
   assign hd_match = (cmd_rn == handle);
   assign in_round = (state_q == StArb) || (state_q == StReply);
   assign secured  = (state_q == StAcked) || (state_q == StOpen);

   always_comb begin
      case (cmd_updn)
         3'b110:  q_adj = (q_q == 4'hF) ? q_q : q_q + 4'd1;
         3'b011:  q_adj = (q_q == 4'h0) ? q_q : q_q - 4'd1;
         default: q_adj = q_q;
      endcase
   end

   always_ff @(posedge DOUB_BLF or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StReady;
         q_q         <= 4'd0;
         ev_q        <= 2'd0;
         qupd_q      <= 1'b0;
         supd_q      <= 1'b0;
         rupd_q      <= 1'b0;
         hupd_q      <= 1'b0;
         req_q       <= 1'b0;
         rtype_q     <= RepRn16;
         pend_q      <= 1'b0;
         pend_type_q <= RepRn16;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         ev_q        <= ev_d;
         qupd_q      <= qupd_d;
         supd_q      <= supd_d;
         rupd_q      <= rupd_d;
         hupd_q      <= hupd_d;
         req_q       <= req_d;
         rtype_q     <= rtype_d;
         pend_q      <= pend_d;
         pend_type_q <= pend_type_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      q_d           = q_q;
      ev_d          = ev_q;
      qupd_d        = 1'b0;
      supd_d        = 1'b0;
      rupd_d        = 1'b0;
      hupd_d        = 1'b0;
      epc_set       = 1'b0;
      pend_set      = 1'b0;
      pend_set_type = RepRn16;
      if (ev_q == 2'd3) begin
         ev_d = 2'd0;
         if (slot_valid) begin
            state_d  = StReply;
            rupd_d   = 1'b1;
            pend_set = 1'b1;
         end else begin
            state_d = StArb;
         end
      end else if (ev_q != 2'd0) begin
         ev_d = ev_q + 2'd1;
      end else if (cmd_acc) begin
         case (cmd_type)
            CmdQuery: begin
               if (cmd_sess_ok) begin
                  q_d    = cmd_q;
                  qupd_d = 1'b1;
                  ev_d   = 2'd1;
               end else begin
                  state_d = StReady;
               end
            end
            CmdQueryAdj: begin
               if (in_round) begin
                  q_d    = q_adj;
                  qupd_d = 1'b1;
                  ev_d   = 2'd1;
               end else if (secured) begin
                  state_d = StReady;
               end
            end
            CmdQueryRep: begin
               if (state_q == StArb) begin
                  supd_d = 1'b1;
                  ev_d   = 2'd1;
               end else if (state_q == StReply) begin
                  state_d = StArb;
               end else if (secured) begin
                  state_d = StReady;
               end
            end
            CmdAck: begin
               if ((state_q == StReply) || (state_q == StAcked)) begin
                  if (rn_match) begin
                     state_d = StAcked;
                     epc_set = 1'b1;
                  end else begin
                     state_d = StArb;
                  end
               end else if ((state_q == StOpen) && hd_match) begin
                  epc_set = 1'b1;
               end
            end
            CmdReqRn: begin
               if ((state_q == StAcked) && rn_match) begin
                  hupd_d        = 1'b1;
                  state_d       = StOpen;
                  pend_set      = 1'b1;
                  pend_set_type = RepHandle;
               end else if ((state_q == StOpen) && hd_match) begin
                  rupd_d   = 1'b1;
                  pend_set = 1'b1;
               end
            end
            CmdNak: begin
               if ((state_q == StReply) || secured) state_d = StArb;
            end
            default: ;
         endcase
      end
   end

   // A pending reply waits one cycle so its request rises after the matching update pulse
   always_comb begin
      req_d       = req_q && !reply_ack;
      rtype_d     = rtype_q;
      pend_d      = pend_q;
      pend_type_d = pend_type_q;
      if (pend_q) begin
         req_d   = 1'b1;
         rtype_d = pend_type_q;
         pend_d  = 1'b0;
      end
      if (cmd_acc) begin
         req_d  = 1'b0;
         pend_d = 1'b0;
      end
      if (epc_set) begin
         req_d   = 1'b1;
         rtype_d = RepEpc;
      end
      if (pend_set) begin
         pend_d      = 1'b1;
         pend_type_d = pend_set_type;
      end
   end

   assign Q             = q_q;
   assign Q_update      = qupd_q;
   assign slot_update   = supd_q;
   assign rn16_update   = rupd_q;
   assign handle_update = hupd_q;
   assign tag_state     = state_q;
   assign reply_req     = req_q;
   assign reply_type    = rtype_q;

endmodule
